// File: rtl/gmsk_pkg.sv
// -----------------------------------------------------------------------------
// gmsk_pkg
// Constants and types shared by the GMSK modulator and demodulator.
//   GMSK_IQ_BITS             width of signed I/Q samples
//   GMSK_SAMPLES_PER_SYMBOL  samples per symbol period (2..64)
//   GMSK_ACC_BITS            demodulator integrate-and-dump accumulator width
//   demod_state_t            demodulator acquisition/tracking state
// -----------------------------------------------------------------------------
package gmsk_pkg;

  localparam int GMSK_IQ_BITS            = 9;
  localparam int GMSK_SAMPLES_PER_SYMBOL = 63;
  localparam int GMSK_ACC_BITS           = 26;

  typedef enum logic [1:0] {
    DEMOD_IDLE  = 2'd0,
    DEMOD_PRIME = 2'd1,
    DEMOD_RUN   = 2'd2
  } demod_state_t;

endpackage

// File: rtl/gmsk_cross_product.sv
// -----------------------------------------------------------------------------
// gmsk_cross_product
// Two-stage pipelined differential phase cross product
//   cross_out = i_prev*q_cur - q_prev*i_cur
// Positive results mean counter-clockwise rotation between the two samples.
//
// Ports
//   clock      system clock
//   reset      synchronous active-high reset (clears the valid pipeline)
//   valid_in   qualifies the four operand inputs
//   i_prev     signed I of the earlier sample
//   q_prev     signed Q of the earlier sample
//   i_cur      signed I of the later sample
//   q_cur      signed Q of the later sample
//   valid_out  qualifies cross_out, two clocks after valid_in
//   cross_out  signed 2*IQ_BITS+1 bit cross product
// -----------------------------------------------------------------------------
module gmsk_cross_product
  import gmsk_pkg::*;
#(
  parameter int IQ_BITS = GMSK_IQ_BITS
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic signed [IQ_BITS-1:0] i_prev,
  input  logic signed [IQ_BITS-1:0] q_prev,
  input  logic signed [IQ_BITS-1:0] i_cur,
  input  logic signed [IQ_BITS-1:0] q_cur,
  output logic                      valid_out,
  output logic signed [2*IQ_BITS:0] cross_out
);

  localparam int PROD_W = 2 * IQ_BITS;
  localparam int DIFF_W = PROD_W + 1;

  logic                     vld_p1;
  logic                     vld_p2;
  logic signed [PROD_W-1:0] prod_a_p1;
  logic signed [PROD_W-1:0] prod_b_p1;
  logic signed [DIFF_W-1:0] diff_p2;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= valid_in;
      vld_p2 <= vld_p1;
    end
  end

  // ---- S1: full-precision products ----
  always_ff @(posedge clock) begin
    if (valid_in) begin
      prod_a_p1 <= PROD_W'(i_prev) * PROD_W'(q_cur);
      prod_b_p1 <= PROD_W'(q_prev) * PROD_W'(i_cur);
    end
  end

  // ---- S2: difference, one extra bit so it never wraps ----
  always_ff @(posedge clock) begin
    if (vld_p1) begin
      diff_p2 <= DIFF_W'(prod_a_p1) - DIFF_W'(prod_b_p1);
    end
  end

  assign valid_out = vld_p2;
  assign cross_out = diff_p2;

endmodule

// File: rtl/gmsk_demodulate.sv
// -----------------------------------------------------------------------------
// gmsk_demodulate
// GMSK I/Q demodulator. Each strobed sample forms a one-sample differential
// cross product with its predecessor; the cross products are integrated over
// a symbol period and dumped into a hard bit, an erasure flag and a soft
// metric. Symbol timing comes from symbol_edge_i; between edges a free-running
// sample counter flywheels the symbol boundaries.
//
// Ports
//   clock            system clock
//   reset            synchronous active-high reset
//   sample_strobe_i  qualifies inphase_in/quadrature_in
//   symbol_edge_i    with the strobe, marks the first sample of a symbol
//   inphase_in       signed I sample
//   quadrature_in    signed Q sample
//   bit_o            recovered bit (held until the next bit_valid_o)
//   bit_valid_o      one-cycle pulse per completed symbol
//   erasure_o        integrated metric exactly zero
//   metric_o         signed integrated cross product
//   realign_o        one-cycle pulse when an edge aborts a partial symbol
//   locked_o         high while tracking (state RUN)
// -----------------------------------------------------------------------------
module gmsk_demodulate
  import gmsk_pkg::*;
#(
  parameter int IQ_BITS            = GMSK_IQ_BITS,
  parameter int SAMPLES_PER_SYMBOL = GMSK_SAMPLES_PER_SYMBOL,
  parameter int ACC_BITS           = GMSK_ACC_BITS,
  parameter int INVERT             = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       sample_strobe_i,
  input  logic                       symbol_edge_i,
  input  logic signed [IQ_BITS-1:0]  inphase_in,
  input  logic signed [IQ_BITS-1:0]  quadrature_in,
  output logic                       bit_o,
  output logic                       bit_valid_o,
  output logic                       erasure_o,
  output logic signed [ACC_BITS-1:0] metric_o,
  output logic                       realign_o,
  output logic                       locked_o
);

  localparam int                CNT_W      = $clog2(SAMPLES_PER_SYMBOL);
  localparam int                CROSS_W    = 2 * IQ_BITS + 1;
  localparam logic [CNT_W-1:0]  LAST_COUNT = CNT_W'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [CNT_W-1:0]  ONE_COUNT  = CNT_W'(1);

  demod_state_t               state;
  logic [CNT_W-1:0]           count;
  logic signed [IQ_BITS-1:0]  i_prev;
  logic signed [IQ_BITS-1:0]  q_prev;

  logic signed [IQ_BITS-1:0]  i_cur_p0;
  logic signed [IQ_BITS-1:0]  q_cur_p0;
  logic signed [IQ_BITS-1:0]  i_prev_p0;
  logic signed [IQ_BITS-1:0]  q_prev_p0;
  logic                       vld_p0;
  logic                       last_p0;
  logic                       clear_p0;
  logic                       last_p1;
  logic                       clear_p1;
  logic                       vld_p2;
  logic                       last_p2;
  logic                       clear_p2;
  logic signed [CROSS_W-1:0]  cross_p2;

  logic signed [ACC_BITS-1:0] acc;
  logic signed [ACC_BITS-1:0] acc_base;
  logic signed [ACC_BITS-1:0] acc_sum;

  logic                       edge_abort;
  logic [CNT_W-1:0]           sample_count;
  logic                       closes_symbol;

  // Wrap-around sample counter step.
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] c);
    return (c == LAST_COUNT) ? '0 : c + ONE_COUNT;
  endfunction

  // Sign-extend a cross product into the accumulator domain.
  function automatic logic signed [ACC_BITS-1:0] extend_cross(
    input logic signed [CROSS_W-1:0] d
  );
    return ACC_BITS'(d);
  endfunction

  // Hard decision; a zero metric yields the INVERT level.
  function automatic logic decide_bit(input logic signed [ACC_BITS-1:0] m);
    logic positive;
    positive = !m[ACC_BITS-1] && (m != '0);
    return positive ^ (INVERT != 0);
  endfunction

  // An edge in RUN away from the expected boundary restarts the symbol at
  // this sample, so this sample is treated as count 0.
  always_comb begin
    edge_abort = 1'b0;
    if ((state == DEMOD_RUN) && symbol_edge_i && (count != '0)) begin
      edge_abort = 1'b1;
    end
    sample_count  = edge_abort ? '0 : count;
    closes_symbol = (sample_count == LAST_COUNT);
  end

  // ---- S0: FSM, counter, sample/prev capture ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= DEMOD_IDLE;
      count     <= '0;
      i_prev    <= '0;
      q_prev    <= '0;
      vld_p0    <= 1'b0;
      last_p0   <= 1'b0;
      clear_p0  <= 1'b0;
      realign_o <= 1'b0;
    end else begin
      vld_p0    <= 1'b0;
      realign_o <= 1'b0;
      if (sample_strobe_i) begin
        case (state)
          DEMOD_IDLE: begin
            if (symbol_edge_i) begin
              i_prev <= inphase_in;
              q_prev <= quadrature_in;
              count  <= ONE_COUNT;
              state  <= DEMOD_PRIME;
            end
          end
          DEMOD_PRIME, DEMOD_RUN: begin
            i_prev <= inphase_in;
            q_prev <= quadrature_in;
            if ((state == DEMOD_PRIME) && symbol_edge_i) begin
              // A fresh edge before the first differential simply
              // restarts acquisition from this sample.
              count <= ONE_COUNT;
            end else begin
              vld_p0    <= 1'b1;
              last_p0   <= closes_symbol;
              // The first differential of an acquisition and the edge
              // sample of a realignment both start from an empty acc.
              clear_p0  <= edge_abort || (state == DEMOD_PRIME);
              realign_o <= edge_abort;
              count     <= next_count(sample_count);
              state     <= DEMOD_RUN;
            end
          end
          default: state <= DEMOD_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (sample_strobe_i) begin
      i_cur_p0  <= inphase_in;
      q_cur_p0  <= quadrature_in;
      i_prev_p0 <= i_prev;
      q_prev_p0 <= q_prev;
    end
  end

  // ---- S1/S2: cross product, control flags delayed alongside ----
  gmsk_cross_product #(
    .IQ_BITS (IQ_BITS)
  ) u_cross (
    .clock     (clock),
    .reset     (reset),
    .valid_in  (vld_p0),
    .i_prev    (i_prev_p0),
    .q_prev    (q_prev_p0),
    .i_cur     (i_cur_p0),
    .q_cur     (q_cur_p0),
    .valid_out (vld_p2),
    .cross_out (cross_p2)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      last_p1  <= 1'b0;
      clear_p1 <= 1'b0;
      last_p2  <= 1'b0;
      clear_p2 <= 1'b0;
    end else begin
      last_p1  <= last_p0;
      clear_p1 <= clear_p0;
      last_p2  <= last_p1;
      clear_p2 <= clear_p1;
    end
  end

  // ---- S3: integrate and dump ----
  always_comb begin
    acc_base = acc;
    if (clear_p2) begin
      acc_base = '0;
    end
    acc_sum = acc_base + extend_cross(cross_p2);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc         <= '0;
      bit_valid_o <= 1'b0;
      bit_o       <= 1'b0;
      erasure_o   <= 1'b0;
      metric_o    <= '0;
    end else begin
      bit_valid_o <= 1'b0;
      if (vld_p2) begin
        if (last_p2) begin
          metric_o    <= acc_sum;
          bit_o       <= decide_bit(acc_sum);
          erasure_o   <= (acc_sum == '0);
          bit_valid_o <= 1'b1;
          acc         <= '0;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

  assign locked_o = (state == DEMOD_RUN);

endmodule
